// File: rtl/reg_file_pkg.sv
// riscpkg: shared constants and helpers for the IITB-RISC register file.
//   DATA_W     register width
//   NREG       number of architectural registers
//   REG_ADDR_W register address width
//   PC_REG     index of the register that doubles as the program counter
//   RESET_PC   value loaded into the PC register at reset
//   CNT_W      width of a pending-write scoreboard counter
package riscpkg;

  localparam int DATA_W     = 16;
  localparam int NREG       = 8;
  localparam int REG_ADDR_W = $clog2(NREG);
  localparam int CNT_W      = 2;

  localparam logic [REG_ADDR_W-1:0] PC_REG   = 3'd7;
  localparam logic [DATA_W-1:0]     RESET_PC = 16'h0000;

  // Read-port mux with forwarding. A write-back to the same register wins;
  // otherwise a sequential PC update is forwarded for reads of the PC register.
  function automatic logic [DATA_W-1:0] read_bypass(
    input logic [REG_ADDR_W-1:0] addr,
    input logic                  wb_act,
    input logic [REG_ADDR_W-1:0] wb_addr,
    input logic [DATA_W-1:0]     wb_data,
    input logic                  pc_act,
    input logic [DATA_W-1:0]     pc_next,
    input logic [DATA_W-1:0]     stored
  );
    logic [DATA_W-1:0] result;
    result = stored;
    if (wb_act && (wb_addr == addr)) begin
      result = wb_data;
    end else if (pc_act && (addr == PC_REG)) begin
      result = pc_next;
    end
    return result;
  endfunction

  // A register is busy while writes are pending, except when the last
  // outstanding write is being written back right now (it is forwarded).
  function automatic logic busy_calc(
    input logic [REG_ADDR_W-1:0] addr,
    input logic [CNT_W-1:0]      cnt,
    input logic                  wb_act,
    input logic [REG_ADDR_W-1:0] wb_addr
  );
    return (cnt != '0) &&
           !(wb_act && (wb_addr == addr) && (cnt == CNT_W'(1)));
  endfunction

endpackage

// File: rtl/reg_file_if.sv
// reg_file_if: write-back, read, PC and issue signals of the register file.
//   master modport: pipeline side (drives write-back, read addresses, PC, issue)
//   slave modport : register file side (returns read data, busy flags, PC, error)
interface reg_file_if;

  logic                             wb_en;
  logic [riscpkg::REG_ADDR_W-1:0]   wb_addr;
  logic [riscpkg::DATA_W-1:0]       wb_data;

  logic [riscpkg::REG_ADDR_W-1:0]   rd_addr_a;
  logic [riscpkg::REG_ADDR_W-1:0]   rd_addr_b;
  logic [riscpkg::DATA_W-1:0]       rd_data_a;
  logic [riscpkg::DATA_W-1:0]       rd_data_b;
  logic                             busy_a;
  logic                             busy_b;

  logic                             pc_we;
  logic [riscpkg::DATA_W-1:0]       pc_next;
  logic [riscpkg::DATA_W-1:0]       pc_out;

  logic                             issue_en;
  logic [riscpkg::REG_ADDR_W-1:0]   issue_addr;
  logic                             sb_err;

  modport master (
    output wb_en, wb_addr, wb_data,
    output rd_addr_a, rd_addr_b,
    input  rd_data_a, rd_data_b, busy_a, busy_b,
    output pc_we, pc_next,
    input  pc_out,
    output issue_en, issue_addr,
    input  sb_err
  );

  modport slave (
    input  wb_en, wb_addr, wb_data,
    input  rd_addr_a, rd_addr_b,
    output rd_data_a, rd_data_b, busy_a, busy_b,
    input  pc_we, pc_next,
    output pc_out,
    input  issue_en, issue_addr,
    output sb_err
  );

endinterface

// File: rtl/reg_file_sb_counter.sv
// sb_counter: 2-bit saturating pending-write counter for one register.
//   clk, resetn : clock and synchronous active-low reset
//   inc_i       : an instruction writing this register has issued
//   dec_i       : a write-back to this register has arrived
//   cnt_o       : current pending count (registered)
//   err_o       : single-cycle pulse on overflow (inc at max) or underflow
//                 (dec at zero); the count saturates in both cases
module sb_counter
  import riscpkg::*;
(
  input  logic             clk,
  input  logic             resetn,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             err_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    err_o = 1'b0;
    unique case ({inc_i, dec_i})
      2'b10: begin
        if (cnt_q == CNT_MAX) err_o = 1'b1;
        else                  cnt_d = cnt_q + CNT_W'(1);
      end
      2'b01: begin
        if (cnt_q == '0) err_o = 1'b1;
        else             cnt_d = cnt_q - CNT_W'(1);
      end
      // Issue and retire in the same cycle cancel out.
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/reg_file.sv
// reg_file: eight-entry 16-bit architectural register file; R7 is the PC.
//   clk    : clock, all state updates on the rising edge
//   resetn : synchronous active-low reset (R0-R6=0, R7=RESET_PC, counters=0)
//   bus    : reg_file_if.slave
//            wb_*        write-back port (write wins over PC update on R7)
//            rd_*_a/b    two combinational read ports with write-back bypass
//            busy_a/b    pending-write hazard flags for the read addresses
//            pc_we/next  sequential PC update; pc_out is the registered R7
//            issue_*     scoreboard increment when a writer leaves decode
//            sb_err      sticky scoreboard overflow/underflow flag
module reg_file
  import riscpkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  reg_file_if.slave  bus
);

  // Inputs are ignored while reset is held, including for forwarding.
  logic wb_act;
  logic pc_act;
  logic issue_act;

  assign wb_act    = bus.wb_en    & resetn;
  assign pc_act    = bus.pc_we    & resetn;
  assign issue_act = bus.issue_en & resetn;

  logic [DATA_W-1:0] regs [NREG];
  logic [CNT_W-1:0]  cnt  [NREG];
  logic [NREG-1:0]   err_vec;

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_reg
      localparam logic [REG_ADDR_W-1:0] IDX     = REG_ADDR_W'(gi);
      localparam logic                  IS_PC   = (IDX == PC_REG);
      localparam logic [DATA_W-1:0]     RST_VAL = IS_PC ? RESET_PC : '0;

      logic              wb_hit;
      logic              issue_hit;
      logic [DATA_W-1:0] reg_q;

      assign wb_hit    = wb_act    && (bus.wb_addr    == IDX);
      assign issue_hit = issue_act && (bus.issue_addr == IDX);

      // Write-back has priority over the sequential PC update on R7.
      always_ff @(posedge clk) begin
        if (!resetn) begin
          reg_q <= RST_VAL;
        end else if (wb_hit) begin
          reg_q <= bus.wb_data;
        end else if (IS_PC && pc_act) begin
          reg_q <= bus.pc_next;
        end
      end

      assign regs[gi] = reg_q;

      sb_counter u_sb_counter (
        .clk    (clk),
        .resetn (resetn),
        .inc_i  (issue_hit),
        .dec_i  (wb_hit),
        .cnt_o  (cnt[gi]),
        .err_o  (err_vec[gi])
      );
    end
  endgenerate

  // Sticky error: once any counter misbehaves, only reset clears it.
  logic sb_err_q;

  always_ff @(posedge clk) begin
    if (!resetn)         sb_err_q <= 1'b0;
    else if (|err_vec)   sb_err_q <= 1'b1;
  end

  assign bus.sb_err = sb_err_q;
  assign bus.pc_out = regs[PC_REG];

  assign bus.rd_data_a = read_bypass(bus.rd_addr_a, wb_act, bus.wb_addr,
                                     bus.wb_data, pc_act, bus.pc_next,
                                     regs[bus.rd_addr_a]);
  assign bus.rd_data_b = read_bypass(bus.rd_addr_b, wb_act, bus.wb_addr,
                                     bus.wb_data, pc_act, bus.pc_next,
                                     regs[bus.rd_addr_b]);

  assign bus.busy_a = busy_calc(bus.rd_addr_a, cnt[bus.rd_addr_a],
                                wb_act, bus.wb_addr);
  assign bus.busy_b = busy_calc(bus.rd_addr_b, cnt[bus.rd_addr_b],
                                wb_act, bus.wb_addr);

endmodule
